// File: rtl/mem_arbiter_if.sv
// Memory-port bundle: request (valid/fence/instr/addr/wdata/wstrb) and response (ready/rdata).
// The master drives the request and the slave answers it.
interface mem_arbiter_if;
  logic        mem_valid;
  logic        mem_fence;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// Data has priority; instr wins after data_burst consecutive data grants while it waits.
module mem_arbiter #(
  parameter int data_burst = 4
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  ireq,
  mem_arbiter_if.slave  dreq,
  mem_arbiter_if.master mem
);
  localparam int CNT_W = (data_burst > 0) ? $clog2(data_burst + 1) : 1;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(data_burst);
  localparam int SIDE_I = 0;
  localparam int SIDE_D = 1;

  typedef struct packed {
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0]       in_valid;
  logic [1:0]       cand;
  logic [1:0]       grant;
  req_t             in_req   [2];
  req_t             cand_req [2];
  req_t             grant_req;
  logic             iresp_ready, dresp_ready;
  logic [31:0]      iresp_rdata, dresp_rdata;
  logic             unused_instr;

  assign in_valid         = {dreq.mem_valid, ireq.mem_valid};
  assign in_req[SIDE_I]   = {ireq.mem_fence, ireq.mem_addr, ireq.mem_wdata, ireq.mem_wstrb};
  assign in_req[SIDE_D]   = {dreq.mem_fence, dreq.mem_addr, dreq.mem_wdata, dreq.mem_wstrb};
  // The issued mem_instr is derived from the granted side, so the incoming field is ignored.
  assign unused_instr     = ireq.mem_instr ^ dreq.mem_instr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      logic valid_q;
      req_t req_q;

      // Granted requests are never stored; otherwise the newest request overwrites the slot.
      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_q <= 1'b0;
          req_q   <= '0;
        end else if (grant[gi]) begin
          valid_q <= 1'b0;
        end else if (in_valid[gi]) begin
          valid_q <= 1'b1;
          req_q   <= in_req[gi];
        end
      end

      assign cand[gi]     = in_valid[gi] | valid_q;
      assign cand_req[gi] = in_valid[gi] ? in_req[gi] : req_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant       = '0;
    iresp_ready = 1'b0;
    iresp_rdata = '0;
    dresp_ready = 1'b0;
    dresp_rdata = '0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (cand[SIDE_D] && !(cand[SIDE_I] && starve_cnt_q == BURST_MAX)) begin
            grant[SIDE_D] = 1'b1;
            state_d       = BUSY_D;
          end else if (cand[SIDE_I]) begin
            grant[SIDE_I] = 1'b1;
            state_d       = BUSY_I;
          end
        end
        BUSY_I: begin
          if (mem.mem_ready) begin
            iresp_ready = 1'b1;
            iresp_rdata = mem.mem_rdata;
            state_d     = IDLE;
          end
        end
        BUSY_D: begin
          if (mem.mem_ready) begin
            dresp_ready = 1'b1;
            dresp_rdata = mem.mem_rdata;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Only data grants made over a waiting instr request count towards starvation.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant[SIDE_I]) begin
      starve_cnt_d = '0;
    end else if (grant[SIDE_D] && cand[SIDE_I] && starve_cnt_q != BURST_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  assign grant_req = grant[SIDE_D] ? cand_req[SIDE_D] :
                     grant[SIDE_I] ? cand_req[SIDE_I] : '0;

  assign mem.mem_valid  = |grant;
  assign mem.mem_instr  = grant[SIDE_I];
  assign mem.mem_fence  = grant_req.fence;
  assign mem.mem_addr   = grant_req.addr;
  assign mem.mem_wdata  = grant_req.wdata;
  assign mem.mem_wstrb  = grant_req.wstrb;

  assign ireq.mem_ready = iresp_ready;
  assign ireq.mem_rdata = iresp_rdata;
  assign dreq.mem_ready = dresp_ready;
  assign dreq.mem_rdata = dresp_rdata;
endmodule
